// File: rtl/alu_pkg.sv
// Shared ALU operation encodings for the RV32I execute stage.
package alu_pkg;

    localparam int ALU_FUN_W = 4;

    typedef enum logic [ALU_FUN_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU compute core; with ALU_FLAGS_EN it also produces carry/overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    input  logic [ALU_FUN_W-1:0] alu_fun_i,
`ifdef ALU_FLAGS_EN
    output logic                 carry_o,
    output logic                 ovf_o,
`endif
    output logic [WIDTH-1:0]     result_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SH_W-1:0]  shamt;
    logic        [WIDTH-1:0] sum;
    logic        [WIDTH-1:0] diff;

    assign a_s   = op_a_i;
    assign b_s   = op_b_i;
    assign shamt = op_b_i[SH_W-1:0];

`ifdef ALU_FLAGS_EN
    // Carry of SUB is taken from A + ~B + 1, so it reads as not-borrow.
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;

    assign add_w = {1'b0, op_a_i} + {1'b0, op_b_i};
    assign sub_w = {1'b0, op_a_i} + {1'b0, ~op_b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign sum   = add_w[WIDTH-1:0];
    assign diff  = sub_w[WIDTH-1:0];
`else
    assign sum   = op_a_i + op_b_i;
    assign diff  = op_a_i - op_b_i;
`endif

    always_comb begin
        result_o = '0;
`ifdef ALU_FLAGS_EN
        carry_o  = 1'b0;
        ovf_o    = 1'b0;
`endif
        case (alu_fun_e'(alu_fun_i))
            ALU_ADD: begin
                result_o = sum;
`ifdef ALU_FLAGS_EN
                carry_o  = add_w[WIDTH];
                ovf_o    = (op_a_i[WIDTH-1] == op_b_i[WIDTH-1]) &&
                           (sum[WIDTH-1] != op_a_i[WIDTH-1]);
`endif
            end
            ALU_SUB: begin
                result_o = diff;
`ifdef ALU_FLAGS_EN
                carry_o  = sub_w[WIDTH];
                ovf_o    = (op_a_i[WIDTH-1] != op_b_i[WIDTH-1]) &&
                           (diff[WIDTH-1] != op_a_i[WIDTH-1]);
`endif
            end
            ALU_OR:   result_o = op_a_i | op_b_i;
            ALU_AND:  result_o = op_a_i & op_b_i;
            ALU_XOR:  result_o = op_a_i ^ op_b_i;
            ALU_SRL:  result_o = op_a_i >> shamt;
            ALU_SLL:  result_o = op_a_i << shamt;
            ALU_SRA:  result_o = a_s >>> shamt;
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
            ALU_LUI:  result_o = op_a_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered RV32I ALU: one-cycle latency, IN_VALID-qualified output stage.
// Optional flag outputs NEG/CARRY/OVF are built when ALU_FLAGS_EN is defined.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [WIDTH-1:0]     OP_A,
    input  logic [WIDTH-1:0]     OP_B,
    input  logic [ALU_FUN_W-1:0] ALU_FUN,
    input  logic                 IN_VALID,
    output logic [WIDTH-1:0]     RESULT,
    output logic                 ZERO,
`ifdef ALU_FLAGS_EN
    output logic                 NEG,
    output logic                 CARRY,
    output logic                 OVF,
`endif
    output logic                 OUT_VALID
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             vld_q;

`ifdef ALU_FLAGS_EN
    logic carry_d;
    logic ovf_d;
    logic neg_q;
    logic carry_q;
    logic ovf_q;
`endif

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_a_i    (OP_A),
        .op_b_i    (OP_B),
        .alu_fun_i (ALU_FUN),
`ifdef ALU_FLAGS_EN
        .carry_o   (carry_d),
        .ovf_o     (ovf_d),
`endif
        .result_o  (result_d)
    );

    // Output stage: data and flags only move on IN_VALID, valid follows every cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            vld_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            vld_q <= IN_VALID;
            if (IN_VALID) begin
                result_q <= result_d;
                zero_q   <= (result_d == '0);
`ifdef ALU_FLAGS_EN
                neg_q    <= result_d[WIDTH-1];
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
`endif
            end
        end
    end

    assign RESULT    = result_q;
    assign ZERO      = zero_q;
    assign OUT_VALID = vld_q;
`ifdef ALU_FLAGS_EN
    assign NEG   = neg_q;
    assign CARRY = carry_q;
    assign OVF   = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: directed vectors plus randomized traffic vs. a reference model.
module tb_alu;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] OP_A;
    logic [31:0] OP_B;
    logic [3:0]  ALU_FUN;
    logic        IN_VALID;
    logic [31:0] RESULT;
    logic        ZERO;
    logic        OUT_VALID;
`ifdef ALU_FLAGS_EN
    logic        NEG;
    logic        CARRY;
    logic        OVF;
`endif

    alu #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .ALU_FUN   (ALU_FUN),
        .IN_VALID  (IN_VALID),
        .RESULT    (RESULT),
        .ZERO      (ZERO),
`ifdef ALU_FLAGS_EN
        .NEG       (NEG),
        .CARRY     (CARRY),
        .OVF       (OVF),
`endif
        .OUT_VALID (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        o;
        logic [3:0]  f;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model straight from the operation table.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        exp_t   e;
        int     sh;
        longint sa, sb, wide;
        logic [32:0] ua;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = 32'd0; e.c = 1'b0; e.o = 1'b0; e.f = f;
        case (f)
            4'd0: begin
                e.res = a + b;
                ua = {1'b0, a} + {1'b0, b};
                e.c = ua[32];
                wide = sa + sb;
                e.o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd8: begin
                e.res = a - b;
                e.c = (a >= b);
                wide = sa - sb;
                e.o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd6: e.res = a | b;
            4'd7: e.res = a & b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = a >> sh;
            4'd1: e.res = a << sh;
            4'd13: e.res = a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd2: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd3: e.res = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            4'd9: e.res = a;
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f, input logic v);
        @(negedge CLK);
        OP_A = a; OP_B = b; ALU_FUN = f; IN_VALID = v;
        if (v && RST_N) exp_q.push_back(model(a, b, f));
    endtask

    // Monitor: pops on every OUT_VALID, checks hold otherwise.
    exp_t last;
    initial begin
        exp_t e;
        last.res = 32'd0; last.z = 1'b1; last.n = 1'b0; last.c = 1'b0; last.o = 1'b0; last.f = 4'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST_N) begin
                last.res = 32'd0; last.z = 1'b1; last.n = 1'b0; last.c = 1'b0; last.o = 1'b0;
            end else if (OUT_VALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result_f%0d", e.f), RESULT, e.res);
                    check($sformatf("zero_f%0d", e.f), {31'd0, ZERO}, {31'd0, e.z});
`ifdef ALU_FLAGS_EN
                    check($sformatf("neg_f%0d", e.f), {31'd0, NEG}, {31'd0, e.n});
                    check($sformatf("carry_f%0d", e.f), {31'd0, CARRY}, {31'd0, e.c});
                    check($sformatf("ovf_f%0d", e.f), {31'd0, OVF}, {31'd0, e.o});
`endif
                    last = e;
                end
            end else begin
                check("hold_result", RESULT, last.res);
                check("hold_zero", {31'd0, ZERO}, {31'd0, last.z});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rf;
        RST_N = 1'b0; OP_A = 32'h1234_5678; OP_B = 32'h1; ALU_FUN = 4'd0; IN_VALID = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            check("rst_result", RESULT, 32'd0);
            check("rst_zero", {31'd0, ZERO}, 32'd1);
            check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        RST_N = 1'b1;

        drive(32'h0, 32'h0, 4'd0, 1'b1);
        drive(32'h1000_0000, 32'h1000_0000, 4'd0, 1'b1);
        drive(32'h1000_0000, 32'h1000_0000, 4'd8, 1'b1);
        drive(32'hFFFF_FFFF, 32'h1, 4'd0, 1'b1);
        drive(32'h1000_FFFF, 32'h1000_0000, 4'd6, 1'b1);
        drive(32'h1000_FFFF, 32'h1000_0000, 4'd7, 1'b1);
        drive(32'hF0F0_F0F0, 32'hFFFF_FFFF, 4'd4, 1'b1);
        drive(32'h4, 32'h2, 4'd5, 1'b1);
        drive(32'h4, 32'h2, 4'd1, 1'b1);
        drive(32'hF, 32'h1, 4'd13, 1'b1);
        drive(32'h8000_0000, 32'd31, 4'd13, 1'b1);
        drive(32'h1, 32'h21, 4'd1, 1'b1);
        drive(32'hABCD_0123, 32'h20, 4'd5, 1'b1);
        drive(32'h8000_0001, 32'h8000_0010, 4'd2, 1'b1);
        drive(32'h11, 32'h10, 4'd2, 1'b1);
        drive(32'h1, 32'h10, 4'd3, 1'b1);
        drive(32'h11, 32'h10, 4'd3, 1'b1);
        drive(32'h8000_0000, 32'h1, 4'd2, 1'b1);
        drive(32'h8000_0000, 32'h1, 4'd3, 1'b1);
        drive(32'hFFFF_0000, 32'h0000_FFFF, 4'd9, 1'b1);
        drive(32'h1234_5678, 32'h1, 4'd0, 1'b1);
        drive(32'hFFFF_FFFF, 32'h1, 4'd15, 1'b1);
        drive(32'h5555_5555, 32'h1, 4'd0, 1'b0);
        drive(32'h5555_5555, 32'h1, 4'd0, 1'b0);
        drive(32'h7FFF_FFFF, 32'h1, 4'd0, 1'b1);
        drive(32'h8000_0000, 32'h1, 4'd8, 1'b1);
        drive(32'h5, 32'h7, 4'd8, 1'b1);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = ra;
            rf = 4'($urandom_range(0, 15));
            drive(ra, rb, rf, ($urandom_range(0, 4) != 0));
        end
        drive(32'h0, 32'h0, 4'd0, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during an in-flight operation drops it.
        drive(32'h1, 32'h1, 4'd0, 1'b1);
        @(negedge CLK);
        OP_A = 32'h0F00_0000; OP_B = 32'h1; ALU_FUN = 4'd0; IN_VALID = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_result", RESULT, 32'd0);
        check("async_rst_zero", {31'd0, ZERO}, 32'd1);
        check("async_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK); #1;
        check("midop_rst_result", RESULT, 32'd0);
        check("midop_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        @(negedge CLK);
        IN_VALID = 1'b0;
        RST_N = 1'b1;
        drive(32'h0000_0003, 32'h0000_0004, 4'd0, 1'b1);
        drive(32'h0, 32'h0, 4'd0, 1'b0);
        repeat (2) @(posedge CLK);
        #2;
        check("queue_drained_final", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
